// File: rtl/dma_engine_pkg.sv
// Shared register map, control/status bit positions and FSM states for the word-copy DMA engine.
package dma_engine_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_SRC   = 2'd1;
  localparam logic [1:0] REG_DST   = 2'd2;
  localparam logic [1:0] REG_COUNT = 2'd3;

  localparam int unsigned BIT_START = 0;
  localparam int unsigned BIT_IE    = 1;
  localparam int unsigned BIT_ABORT = 2;
  localparam int unsigned BIT_ACK   = 3;
  localparam int unsigned BIT_BUSY  = 4;
  localparam int unsigned BIT_DONE  = 5;
  localparam int unsigned BIT_ERR   = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr
  } dma_state_e;

endpackage

// File: rtl/dma_regfile.sv
// Slave-side register window: SRC/DST/COUNT/IE storage, progress updates, DONE/ERR flags and Dout mux.
module dma_regfile
  import dma_engine_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       addr_i,
  input  logic             we_i,
  input  logic [31:0]      din_i,
  input  logic             busy_i,
  input  logic             commit_i,
  input  logic             clear_flags_i,
  input  logic             set_done_i,
  input  logic             set_err_i,
  output logic [31:0]      dout_o,
  output logic [31:0]      src_o,
  output logic [31:0]      dst_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             irq_o
);

  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ie_q, ie_d, done_q, done_d, err_q, err_d;
  logic             wr_ctrl;

  assign wr_ctrl = we_i && (addr_i == REG_CTRL);

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    ie_d   = ie_q;
    done_d = done_q;
    err_d  = err_q;
    if (we_i && !busy_i) begin
      unique case (addr_i)
        REG_SRC:   src_d = {din_i[31:2], 2'b00};
        REG_DST:   dst_d = {din_i[31:2], 2'b00};
        REG_COUNT: cnt_d = din_i[CNT_W-1:0];
        default:   ;
      endcase
    end
    if (commit_i) begin
      src_d = src_q + 32'd4;
      dst_d = dst_q + 32'd4;
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (wr_ctrl) ie_d = din_i[BIT_IE];
    if ((wr_ctrl && din_i[BIT_ACK]) || clear_flags_i) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    // Set events take priority over ACK in the same cycle.
    if (set_done_i) done_d = 1'b1;
    if (set_err_i)  err_d  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      src_q  <= src_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
      ie_q   <= ie_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    dout_o = '0;
    unique case (addr_i)
      REG_CTRL: begin
        dout_o[BIT_IE]   = ie_q;
        dout_o[BIT_BUSY] = busy_i;
        dout_o[BIT_DONE] = done_q;
        dout_o[BIT_ERR]  = err_q;
      end
      REG_SRC:   dout_o = src_q;
      REG_DST:   dout_o = dst_q;
      REG_COUNT: dout_o = 32'(cnt_q);
      default:   dout_o = '0;
    endcase
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign cnt_o = cnt_q;
  assign irq_o = ie_q & (done_q | err_q);

endmodule

// File: rtl/dma_engine.sv
// Word-copy DMA: read-then-write transfer FSM driving the bridge master port, with a slave register window.
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic [31:0] m_address,
  output logic        m_readEnable,
  output logic        m_writeEnable,
  output logic [31:0] m_writeData,
  input  logic [31:0] m_readData,
  input  logic        m_exception,
  input  logic        m_grant
);

  dma_state_e       state_q, state_d;
  logic [31:0]      data_q, data_d, addr_q, addr_d, wdata_q, wdata_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [31:0]      src, dst;
  logic [CNT_W-1:0] cnt;
  logic             busy, ctrl_wr, start, abort;
  logic             commit, clear_flags, set_done, set_err;
  logic             unused_addr;

  assign unused_addr = ^Addr[29:2];
  assign busy        = (state_q != StIdle);
  assign ctrl_wr     = WE && (Addr[1:0] == REG_CTRL);
  assign start       = ctrl_wr && Din[BIT_START];
  assign abort       = ctrl_wr && Din[BIT_ABORT];

  dma_regfile #(
    .CNT_W(CNT_W)
  ) u_regfile (
    .clk_i        (clk),
    .rst_ni       (reset),
    .addr_i       (Addr[1:0]),
    .we_i         (WE),
    .din_i        (Din),
    .busy_i       (busy),
    .commit_i     (commit),
    .clear_flags_i(clear_flags),
    .set_done_i   (set_done),
    .set_err_i    (set_err),
    .dout_o       (Dout),
    .src_o        (src),
    .dst_o        (dst),
    .cnt_o        (cnt),
    .irq_o        (IRQ)
  );

  // Request outputs are computed for the next state so they leave the flops cleanly.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    commit      = 1'b0;
    clear_flags = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (cnt != '0)) begin
          clear_flags = 1'b1;
          state_d     = StRd;
          rd_d        = 1'b1;
          addr_d      = src;
        end else if (start) begin
          set_done = 1'b1;
        end
      end
      StRd: begin
        if (abort) begin
          state_d = StIdle;
        end else if (m_grant && m_exception) begin
          set_err = 1'b1;
          state_d = StIdle;
        end else if (m_grant) begin
          data_d  = m_readData;
          state_d = StWr;
          wr_d    = 1'b1;
          addr_d  = dst;
          wdata_d = m_readData;
        end else begin
          rd_d   = 1'b1;
          addr_d = src;
        end
      end
      StWr: begin
        if (abort) begin
          state_d = StIdle;
        end else if (m_grant && m_exception) begin
          set_err = 1'b1;
          state_d = StIdle;
        end else if (m_grant) begin
          commit = 1'b1;
          if (cnt == CNT_W'(1)) begin
            set_done = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StRd;
            rd_d    = 1'b1;
            addr_d  = src + 32'd4;
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = dst;
          wdata_d = data_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign m_readEnable  = rd_q;
  assign m_writeEnable = wr_q;
  assign m_address     = addr_q;
  assign m_writeData   = wdata_q;

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: stimulus queues expected bus transfers, a bus-responder monitor checks them.
module tb_dma_engine;
  import dma_engine_pkg::*;

  localparam int unsigned CntW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din, Dout;
  logic        IRQ;
  logic [31:0] m_address, m_writeData;
  logic        m_readEnable, m_writeEnable;
  logic [31:0] m_readData = '0;
  logic        m_exception = 1'b0;
  logic        m_grant = 1'b0;

  always #5 clk = ~clk;

  dma_engine #(.CNT_W(CntW)) dut (
    .clk          (clk),
    .reset        (reset),
    .Addr         (Addr),
    .WE           (WE),
    .Din          (Din),
    .Dout         (Dout),
    .IRQ          (IRQ),
    .m_address    (m_address),
    .m_readEnable (m_readEnable),
    .m_writeEnable(m_writeEnable),
    .m_writeData  (m_writeData),
    .m_readData   (m_readData),
    .m_exception  (m_exception),
    .m_grant      (m_grant)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          gmode = 0;     // 0 always grant, 1 random, 2 never, 3 grant until glimit accepts
  int          glimit = 0;
  int          exc_at = -1;   // job-relative accept index that gets m_exception
  int          acc_total = 0;
  int          acc_base = 0;
  logic [31:0] seed = 32'h1234_5678;

  localparam logic [31:0] CStart = 32'h1 << BIT_START;
  localparam logic [31:0] CIe    = 32'h1 << BIT_IE;
  localparam logic [31:0] CAbort = 32'h1 << BIT_ABORT;
  localparam logic [31:0] CAck   = 32'h1 << BIT_ACK;
  localparam logic [31:0] SBusy  = 32'h1 << BIT_BUSY;
  localparam logic [31:0] SDone  = 32'h1 << BIT_DONE;
  localparam logic [31:0] SErr   = 32'h1 << BIT_ERR;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder and monitor: grants, supplies read data, pops and compares accepted requests.
  always @(negedge clk) begin
    bit    g;
    xfer_t e;
    g = (gmode == 0) || (gmode == 1 && $urandom_range(0, 2) != 0) ||
        (gmode == 3 && (acc_total - acc_base) < glimit);
    m_grant     = 1'b0;
    m_exception = 1'b0;
    m_readData  = '0;
    if (m_readEnable || m_writeEnable)
      chk("one_req", {31'b0, m_readEnable & m_writeEnable}, 32'd0);
    if (reset && g && (m_readEnable || m_writeEnable)) begin
      m_grant = 1'b1;
      if (m_readEnable) m_readData = mem(m_address);
      if ((acc_total - acc_base) == exc_at) m_exception = 1'b1;
      acc_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got addr %h expected no request", m_address);
      end else begin
        e = exp_q.pop_front();
        chk("req_dir", {31'b0, m_writeEnable}, {31'b0, e.wr});
        chk("req_addr", m_address, e.addr);
        if (e.wr) chk("wr_data", m_writeData, e.data);
      end
    end
  end

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'b0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'b0, a};
    #1 d = Dout;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int          n;
    n = 0;
    do begin
      @(negedge clk);
      reg_rd(REG_CTRL, s);
      n++;
    end while (s[BIT_BUSY] && n < 3000);
    chk("idle_timeout", {31'b0, s[BIT_BUSY]}, 32'd0);
  endtask

  // Reference: word i reads src+4i then writes dst+4i; an exception at accept k commits k/2 words.
  task automatic push_job(input logic [31:0] s, input logic [31:0] d, input int n, input int exc);
    xfer_t x;
    int    k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      x.wr = 1'b0; x.addr = s + 32'(4 * i); x.data = '0;
      if (exc < 0 || k <= exc) exp_q.push_back(x);
      k++;
      x.wr = 1'b1; x.addr = d + 32'(4 * i); x.data = mem(s + 32'(4 * i));
      if (exc < 0 || k <= exc) exp_q.push_back(x);
      k++;
    end
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int n,
                         input int exc, input int gm);
    logic [31:0] s, d, r;
    int          c;
    seed = $urandom;
    exp_q.delete();
    gmode  = gm;
    exc_at = exc;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    push_job(s, d, n, exc);
    reg_wr(REG_SRC, src);
    reg_wr(REG_DST, dst);
    reg_wr(REG_COUNT, 32'(n));
    acc_base = acc_total;
    reg_wr(REG_CTRL, CStart | CIe);
    wait_idle();
    c = (exc < 0) ? n : exc / 2;
    reg_rd(REG_SRC, r);   chk("job_src", r, s + 32'(4 * c));
    reg_rd(REG_DST, r);   chk("job_dst", r, d + 32'(4 * c));
    reg_rd(REG_COUNT, r); chk("job_count", r, 32'(n - c));
    reg_rd(REG_CTRL, r);  chk("job_status", r, CIe | ((exc < 0) ? SDone : SErr));
    chk("job_irq", {31'b0, IRQ}, 32'd1);
    chk("job_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] r, s;
    xfer_t       x;
    int          n, exc;

    reset = 1'b0; Addr = '0; WE = 1'b0; Din = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd", {31'b0, m_readEnable}, 32'd0);
    chk("rst_addr", m_address, 32'd0);
    chk("rst_irq", {31'b0, IRQ}, 32'd0);
    reg_rd(REG_CTRL, r); chk("rst_status", r, 32'd0);
    reset = 1'b1;

    // Reset asserted while a read request is pending.
    gmode = 2;
    exp_q.delete();
    reg_wr(REG_SRC, 32'h900);
    reg_wr(REG_COUNT, 32'd4);
    reg_wr(REG_CTRL, CStart | CIe);
    #1;
    chk("pre_rst_rd", {31'b0, m_readEnable}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_rd", {31'b0, m_readEnable}, 32'd0);
    chk("midrst_wr", {31'b0, m_writeEnable}, 32'd0);
    chk("midrst_addr", m_address, 32'd0);
    chk("midrst_wdata", m_writeData, 32'd0);
    chk("midrst_irq", {31'b0, IRQ}, 32'd0);
    reg_rd(REG_SRC, r);   chk("midrst_src", r, 32'd0);
    reg_rd(REG_COUNT, r); chk("midrst_count", r, 32'd0);
    reg_rd(REG_CTRL, r);  chk("midrst_status", r, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic copy; low SRC bits are dropped.
    run_job(32'h103, 32'h200, 3, -1, 0);

    // Stalled read, busy write-protect, IE writes honoured while busy.
    seed = $urandom;
    exp_q.delete();
    gmode = 2; exc_at = -1;
    x.wr = 1'b0; x.addr = 32'h300; x.data = '0; exp_q.push_back(x);
    x.wr = 1'b1; x.addr = 32'h400; x.data = mem(32'h300); exp_q.push_back(x);
    reg_wr(REG_SRC, 32'h300);
    reg_wr(REG_DST, 32'h400);
    reg_wr(REG_COUNT, 32'd1);
    acc_base = acc_total;
    reg_wr(REG_CTRL, CStart | CIe);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_rd", {31'b0, m_readEnable}, 32'd1);
      chk("stall_addr", m_address, 32'h300);
    end
    reg_rd(REG_COUNT, r); chk("stall_count", r, 32'd1);
    reg_wr(REG_SRC, 32'hDEAD_0000);
    reg_rd(REG_SRC, r); chk("busy_src_protect", r, 32'h300);
    reg_wr(REG_CTRL, 32'd0);
    reg_rd(REG_CTRL, r); chk("busy_ie_write", r, SBusy);
    gmode = 0;
    wait_idle();
    reg_rd(REG_CTRL, r); chk("stall_status", r, SDone);
    chk("stall_irq_masked", {31'b0, IRQ}, 32'd0);
    chk("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // Exception on the second word's write grant.
    run_job(32'h100, 32'h200, 3, 3, 0);

    // Abort with a write pending after three accepts.
    seed = $urandom;
    exp_q.delete();
    exc_at = -1;
    push_job(32'h500, 32'h600, 5, -1);
    reg_wr(REG_SRC, 32'h500);
    reg_wr(REG_DST, 32'h600);
    reg_wr(REG_COUNT, 32'd5);
    acc_base = acc_total;
    glimit = 3;
    gmode = 3;
    reg_wr(REG_CTRL, CStart | CIe);
    for (int i = 0; i < 100 && (acc_total - acc_base) < 3; i++) @(negedge clk);
    chk("abort_accepts", 32'(acc_total - acc_base), 32'd3);
    repeat (2) @(negedge clk);
    reg_wr(REG_CTRL, CAbort | CIe);
    #1;
    chk("abort_rd", {31'b0, m_readEnable}, 32'd0);
    chk("abort_wr", {31'b0, m_writeEnable}, 32'd0);
    chk("abort_irq", {31'b0, IRQ}, 32'd0);
    reg_rd(REG_CTRL, r);  chk("abort_status", r, CIe);
    reg_rd(REG_SRC, r);   chk("abort_src", r, 32'h504);
    reg_rd(REG_DST, r);   chk("abort_dst", r, 32'h604);
    reg_rd(REG_COUNT, r); chk("abort_count", r, 32'd4);
    exp_q.delete();

    // Zero count completes immediately with no bus activity.
    gmode = 0;
    reg_wr(REG_COUNT, 32'd0);
    reg_wr(REG_CTRL, CStart | CIe);
    #1;
    reg_rd(REG_CTRL, r); chk("zero_status", r, CIe | SDone);
    chk("zero_irq", {31'b0, IRQ}, 32'd1);
    chk("zero_no_rd", {31'b0, m_readEnable}, 32'd0);

    // Address wrap.
    run_job(32'hFFFF_FFFC, 32'h1000, 2, -1, 1);

    // ACK racing the DONE set, then a plain ACK.
    seed = $urandom;
    exp_q.delete();
    exc_at = -1;
    push_job(32'h700, 32'h800, 1, -1);
    reg_wr(REG_SRC, 32'h700);
    reg_wr(REG_DST, 32'h800);
    reg_wr(REG_COUNT, 32'd1);
    acc_base = acc_total;
    gmode = 0;
    reg_wr(REG_CTRL, CStart | CIe);
    reg_wr(REG_CTRL, CAck | CIe);
    #1;
    reg_rd(REG_CTRL, r); chk("ack_race_done", r, CIe | SDone);
    reg_wr(REG_CTRL, CAck | CIe);
    #1;
    reg_rd(REG_CTRL, r); chk("ack_clear", r, CIe);
    chk("ack_irq", {31'b0, IRQ}, 32'd0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      n = $urandom_range(1, 6);
      exc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
      run_job(s, $urandom, n, exc, $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
